// File: rtl/io_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : io_bus_arbiter_if
//  Brief    : Master request/ack and device bus signals of the two-master
//             I/O bus arbiter (DBUS tristate stays a plain module port).
//  Revision : 1.0  initial release
// ============================================================================
interface io_bus_arbiter_if #(
   parameter int BITS = 32
);
   logic            REQ0;
   logic [BITS-1:0] ADDR0;
   logic [BITS-1:0] WDATA0;
   logic            WE0;
   logic            ACK0;

   logic            REQ1;
   logic [BITS-1:0] ADDR1;
   logic [BITS-1:0] WDATA1;
   logic            WE1;
   logic            ACK1;

   logic [BITS-1:0] RDATA;
   logic            GNT;
   logic            BUSY;
   logic [BITS-1:0] ABUS;
   logic            WE;

   modport slave (
      input  REQ0, ADDR0, WDATA0, WE0,
      input  REQ1, ADDR1, WDATA1, WE1,
      output ACK0, ACK1, RDATA, GNT, BUSY, ABUS, WE
   );

   modport master (
      output REQ0, ADDR0, WDATA0, WE0,
      output REQ1, ADDR1, WDATA1, WE1,
      input  ACK0, ACK1, RDATA, GNT, BUSY, ABUS, WE
   );
endinterface
`default_nettype wire

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : io_bus_arbiter
//  Brief    : Two-master arbiter serialising single-word transactions onto
//             the shared device bus (IDLE -> ACCESS -> DONE).
//             Define ARB_FIXED_PRIO_EN for fixed priority (master 0 wins
//             ties); default is round-robin.
//  Revision : 1.0  initial release
// ============================================================================
module io_bus_arbiter #(
   parameter int BITS = 32
) (
   input  wire             CLK,
   input  wire             RESET_N,
   io_bus_arbiter_if.slave bus,
   inout  wire [BITS-1:0]  DBUS
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [BITS-1:0] r_addr;
   logic [BITS-1:0] r_wdata;
   logic            r_we;
   logic [BITS-1:0] r_rdata;
   logic            r_gnt;
   logic            r_last;

   logic            w_req_any;
   logic            w_win;
   logic            w_latch;
   logic            w_access;

   // Winner selection; only consumed on the IDLE latch edge.
   always_comb begin
      w_req_any = bus.REQ0 | bus.REQ1;
`ifdef ARB_FIXED_PRIO_EN
      w_win     = ~bus.REQ0;
`else
      if (bus.REQ0 && bus.REQ1) begin
         w_win = ~r_last;
      end else begin
         w_win = bus.REQ1;
      end
`endif
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req_any) begin
               w_state_nxt = S_ACCESS;
               w_latch     = 1'b1;
            end
         end
         S_ACCESS: w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Payload is frozen at the latch edge so later master changes are ignored.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_gnt   <= 1'b0;
         r_last  <= 1'b1;
         r_rdata <= '0;
      end else begin
         if (w_latch) begin
            r_addr  <= w_win ? bus.ADDR1  : bus.ADDR0;
            r_wdata <= w_win ? bus.WDATA1 : bus.WDATA0;
            r_we    <= w_win ? bus.WE1    : bus.WE0;
            r_gnt   <= w_win;
            r_last  <= w_win;
         end
         if (r_state == S_ACCESS && !r_we) begin
            r_rdata <= DBUS;
         end
      end
   end

   // Bus outputs decode straight from state so a reset releases them at once.
   assign w_access = (r_state == S_ACCESS);
   assign bus.ABUS = w_access ? r_addr : '0;
   assign bus.WE   = w_access & r_we;
   assign DBUS     = (w_access && r_we) ? r_wdata : {BITS{1'bz}};

   assign bus.ACK0  = (r_state == S_DONE) && !r_gnt;
   assign bus.ACK1  = (r_state == S_DONE) &&  r_gnt;
   assign bus.RDATA = r_rdata;
   assign bus.GNT   = r_gnt;
   assign bus.BUSY  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Two-master arbiter for the shared memory-mapped device bus (ABUS/DBUS/WE) used by the LED, switch, key and timer devices.
- Master 0 is the CPU data port. Master 1 is a secondary master, such as the debug loader or DMA.
- Serialises one single-word transaction at a time onto the bus, captures read data and returns a one-cycle ack to the winning master.

Parameters:
- BITS, 32, width of address and data buses.

Ports:
- CLK  in  1  system clock, all state updates on posedge.
- RESET_N  in  1  asynchronous active-low reset.
- REQ0  in  1  master 0 transaction request, level, held until ACK0.
- ADDR0  in  BITS  master 0 address.
- WDATA0  in  BITS  master 0 write data.
- WE0  in  1  master 0 write enable (1=write, 0=read).
- ACK0  out  1  one-cycle completion pulse to master 0.
- REQ1, ADDR1, WDATA1, WE1, ACK1: same as master 0, for master 1.
- RDATA  out  BITS  read data of the last completed read, valid while ACKx=1.
- GNT  out  1  index of the current or last granted master.
- BUSY  out  1  high in ACCESS and DONE states.
- ABUS  out  BITS  device address bus.
- DBUS  inout  BITS  device data bus, driven only during write ACCESS.
- WE  out  1  device write strobe.

Behaviour:
- Reset (RESET_N=0, async): state=IDLE; ACK0=ACK1=0; RDATA=0; GNT=0; BUSY=0; ABUS=0; WE=0; DBUS=Z; round-robin pointer LAST=1, so master 0 wins the first tie. Reset mid-transaction aborts it; no ack is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Bus idle: ABUS=0, WE=0, DBUS=Z.
  - On posedge with any REQ high, select a winner, latch its ADDR/WDATA/WE into internal registers, set GNT=winner, LAST=winner, and go to ACCESS.
  - No request: stay in IDLE.
- Arbitration: only one request high → that master wins. Both high → the master != LAST wins (round-robin).
- ACCESS (exactly 1 cycle):
  - ABUS=latched address, WE=latched we.
  - Write: DBUS=latched wdata. Read: DBUS=Z; the addressed device drives it combinationally.
  - On posedge, devices perform the write. For a read, RDATA<=DBUS. Go to DONE.
- DONE (exactly 1 cycle):
  - Bus returns to idle values.
  - ACK[GNT]=1, other ACK=0. RDATA holds its value. Next state is IDLE.
- Latency: REQ sampled high at edge k → ACCESS during cycle k..k+1 → ACK high during cycle k+1..k+2. Sustained throughput is one transaction per 3 cycles.
- Requester contract:
  - Hold REQ/ADDR/WDATA/WE stable until ACK is seen.
  - Drop REQ at the edge ending the ACK cycle; a REQ still high in the following IDLE is a new transaction.
  - Changes to a master's inputs after the latch edge are ignored for the current transaction.
- A request from the losing master stays pending and is granted at the next IDLE. With alternating demand, strict alternation is guaranteed (no starvation).
- Write transactions leave RDATA unchanged.
- A read of an unmapped address (no driver) captures Z/X. The arbiter does not detect this case.
- DBUS is never driven by the arbiter outside write ACCESS, so there is no contention with device read drivers.
- WE is never high outside ACCESS.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority, master 0 always wins ties; LAST is still recorded but unused. Master 1 may starve under continuous master 0 demand.
- Undefined: round-robin as above.

Test Plan:
- Reset: assert RESET_N=0 mid-ACCESS of a write → WE drops to 0 and DBUS goes Z immediately (async). No ACK follows. All outputs read their reset values.
- Single write: REQ0=1, ADDR0=0xF000_0000, WDATA0=0x155, WE0=1 on a bench register device → ABUS=0xF000_0000, WE=1, DBUS=0x155 for exactly one cycle. Device register reads 0x155. ACK0 pulses once, 2 cycles after the request edge.
- Single read: device holds 0x2AA; REQ1 read of 0xF000_0000 → DBUS=Z from arbiter, RDATA=0x0000_02AA with ACK1=1. GNT=1.
- Tie, round-robin: REQ0 and REQ1 both asserted and held continuously, re-raised after each ack → grants alternate 0,1,0,1. Each ack is spaced 3 cycles apart. No lost transactions.
- Tie with ARB_FIXED_PRIO_EN: same stimulus → four consecutive grants to master 0. Master 1 is granted only after REQ0 drops.
- Payload change: ADDR0 changed during ACCESS → ABUS keeps the latched address for that cycle.
